pipe_stage_reg: RTL and testbench

//  Parametrised pipeline stage register; next generation of the IF/ID, ID/EX, EX/MEM, MEM/WB regs.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_sat_counter.sv | 26 ++
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32IM pipeline stage registers: occupancy state encoding,
// ID/EX control-word field layout and the per-stage bubble (NOP) control words.
package pipe_pkg;

  // Occupancy of a stage register: nothing, main entry only, main plus skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // ID/EX control word layout (19 bits, LSB first).
  localparam int unsigned IDEX_CTRL_W          = 19;
  localparam int unsigned IDEX_REG_WRITE_EN_LO = 0;
  localparam int unsigned IDEX_REG_WRITE_EN_W  = 1;
  localparam int unsigned IDEX_WB_SEL_LO       = 1;
  localparam int unsigned IDEX_WB_SEL_W        = 2;
  localparam int unsigned IDEX_MEM_LO          = 3;
  localparam int unsigned IDEX_MEM_W           = 2;
  localparam int unsigned IDEX_BRANCH_JUMP_LO  = 5;
  localparam int unsigned IDEX_BRANCH_JUMP_W   = 2;
  localparam int unsigned IDEX_SEL_LO          = 7;
  localparam int unsigned IDEX_SEL_W           = 3;
  localparam int unsigned IDEX_ALUOP_LO        = 10;
  localparam int unsigned IDEX_ALUOP_W         = 4;
  localparam int unsigned IDEX_WRITE_ADDR_LO   = 14;
  localparam int unsigned IDEX_WRITE_ADDR_W    = 5;

  // Control widths of the later stage registers.
  localparam int unsigned EXMEM_CTRL_W = 10;
  localparam int unsigned MEMWB_CTRL_W = 8;

  // Bubble control words: all write enables low, no branch, no memory access.
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_BUBBLE  = '0;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_BUBBLE = '0;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; sticks at all-ones once reached.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] count_q;

  // Count qualifying cycles until the maximum value, then hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (inc && (count_q != CntMax)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, synchronous flush,
// optional skid entry (registered in_ready) and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32 * 5,
  parameter int unsigned       CTRL_W      = 19,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter bit                SKID_EN     = 1'b1,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  pipe_state_e       state_q;
  logic              push;
  logic              pop;

  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  if (SKID_EN) begin : g_skid
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              in_ready_q;

    assign in_ready = in_ready_q;

    // Two-entry FSM; in_ready is registered as "next state is not FULL".
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q     <= ST_EMPTY;
        in_ready_q  <= 1'b0;
        main_data_q <= '0;
        main_ctrl_q <= CTRL_BUBBLE;
        skid_data_q <= '0;
        skid_ctrl_q <= CTRL_BUBBLE;
      end else if (flush) begin
        // Payload registers keep stale contents; they are masked by out_valid.
        state_q    <= ST_EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            in_ready_q <= 1'b1;
            if (push) begin
              main_data_q <= in_data;
              main_ctrl_q <= in_ctrl;
              state_q     <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (push && pop) begin
              main_data_q <= in_data;
              main_ctrl_q <= in_ctrl;
              in_ready_q  <= 1'b1;
            end else if (push) begin
              skid_data_q <= in_data;
              skid_ctrl_q <= in_ctrl;
              state_q     <= ST_FULL;
              in_ready_q  <= 1'b0;
            end else if (pop) begin
              state_q    <= ST_EMPTY;
              in_ready_q <= 1'b1;
            end else begin
              in_ready_q <= 1'b1;
            end
          end
          ST_FULL: begin
            if (pop) begin
              main_data_q <= skid_data_q;
              main_ctrl_q <= skid_ctrl_q;
              state_q     <= ST_ONE;
              in_ready_q  <= 1'b1;
            end else begin
              in_ready_q <= 1'b0;
            end
          end
          default: begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end else begin : g_single
    // Low during reset and until the first clock edge after release.
    logic started_q;

    assign in_ready = started_q & (~out_valid | out_ready);

    // Single-entry FSM; a push may replace the entry being popped in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q     <= ST_EMPTY;
        started_q   <= 1'b0;
        main_data_q <= '0;
        main_ctrl_q <= CTRL_BUBBLE;
      end else begin
        started_q <= 1'b1;
        if (flush) begin
          state_q <= ST_EMPTY;
        end else if (push) begin
          main_data_q <= in_data;
          main_ctrl_q <= in_ctrl;
          state_q     <= ST_ONE;
        end else if (pop) begin
          state_q <= ST_EMPTY;
        end
      end
    end
  end

  assign out_data = main_data_q;
  assign out_ctrl = out_valid ? main_ctrl_q : CTRL_BUBBLE;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg: queue-based reference model for the
// skid (default) and single-entry variants, plus a 4-bit stall counter saturation check.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 160;
  localparam int unsigned CW = 19;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Skid instance (defaults).
  logic          m_in_valid = 1'b0, m_in_ready, m_flush = 1'b0;
  logic          m_out_valid, m_out_ready = 1'b0;
  logic [DW-1:0] m_in_data = '0, m_out_data;
  logic [CW-1:0] m_in_ctrl = '0, m_out_ctrl;
  logic [15:0]   m_stall;

  // 4-bit stall counter instance.
  logic          c_in_valid = 1'b0, c_in_ready, c_flush = 1'b0;
  logic          c_out_valid, c_out_ready = 1'b0;
  logic [DW-1:0] c_in_data = '0, c_out_data;
  logic [CW-1:0] c_in_ctrl = '0, c_out_ctrl;
  logic [3:0]    c_stall;

  // Single-entry instance.
  logic          n_in_valid = 1'b0, n_in_ready, n_flush = 1'b0;
  logic          n_out_valid, n_out_ready = 1'b0;
  logic [DW-1:0] n_in_data = '0, n_out_data;
  logic [CW-1:0] n_in_ctrl = '0, n_out_ctrl;
  logic [15:0]   n_stall;

  pipe_stage_reg dut_m (
    .clk (clk), .reset (reset), .in_valid (m_in_valid), .in_ready (m_in_ready),
    .in_data (m_in_data), .in_ctrl (m_in_ctrl), .flush (m_flush), .out_valid (m_out_valid),
    .out_ready (m_out_ready), .out_data (m_out_data), .out_ctrl (m_out_ctrl),
    .stall_cnt (m_stall)
  );

  pipe_stage_reg #(.CNT_W (4)) dut_c (
    .clk (clk), .reset (reset), .in_valid (c_in_valid), .in_ready (c_in_ready),
    .in_data (c_in_data), .in_ctrl (c_in_ctrl), .flush (c_flush), .out_valid (c_out_valid),
    .out_ready (c_out_ready), .out_data (c_out_data), .out_ctrl (c_out_ctrl),
    .stall_cnt (c_stall)
  );

  pipe_stage_reg #(.SKID_EN (1'b0)) dut_n (
    .clk (clk), .reset (reset), .in_valid (n_in_valid), .in_ready (n_in_ready),
    .in_data (n_in_data), .in_ctrl (n_in_ctrl), .flush (n_flush), .out_valid (n_out_valid),
    .out_ready (n_out_ready), .out_data (n_out_data), .out_ctrl (n_out_ctrl),
    .stall_cnt (n_stall)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  ent_t mq[$];
  ent_t nq[$];
  int   m_cnt = 0;
  int   n_cnt = 0;
  logic m_rdy = 1'b0;     // model of the registered in_ready of the skid instance
  logic n_started = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < int'(DW); i += 32) r[i+:32] = $urandom;
    return r;
  endfunction

  // One cycle on the skid instance; entered and left at posedge+1.
  task automatic cyc_m(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    logic ps, pp;
    m_in_valid = v; m_in_data = d; m_in_ctrl = c; m_out_ready = ordy; m_flush = fl;
    #1;
    check_eq("m_out_valid", DW'(m_out_valid), DW'(mq.size() != 0));
    check_eq("m_in_ready", DW'(m_in_ready), DW'(m_rdy));
    check_eq("m_stall_cnt", DW'(m_stall), DW'(m_cnt));
    if (mq.size() != 0) begin
      check_eq("m_out_data", m_out_data, mq[0].d);
      check_eq("m_out_ctrl", DW'(m_out_ctrl), DW'(mq[0].c));
    end else begin
      check_eq("m_out_ctrl_bubble", DW'(m_out_ctrl), DW'(0));
    end
    ps = v & m_rdy;
    pp = (mq.size() != 0) & ordy;
    if (mq.size() != 0 && !ordy && m_cnt < 65535) m_cnt++;
    if (fl) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (ps) mq.push_back('{c: c, d: d});
    end
    m_rdy = (mq.size() < 2);
    @(posedge clk);
    #1;
  endtask

  // One cycle on the single-entry instance; in_ready is combinational here.
  task automatic cyc_n(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    logic ps, pp, er;
    n_in_valid = v; n_in_data = d; n_in_ctrl = c; n_out_ready = ordy; n_flush = fl;
    #1;
    er = n_started & ((nq.size() == 0) | ordy);
    check_eq("n_out_valid", DW'(n_out_valid), DW'(nq.size() != 0));
    check_eq("n_in_ready", DW'(n_in_ready), DW'(er));
    check_eq("n_stall_cnt", DW'(n_stall), DW'(n_cnt));
    if (nq.size() != 0) begin
      check_eq("n_out_data", n_out_data, nq[0].d);
      check_eq("n_out_ctrl", DW'(n_out_ctrl), DW'(nq[0].c));
    end else begin
      check_eq("n_out_ctrl_bubble", DW'(n_out_ctrl), DW'(0));
    end
    ps = v & er;
    pp = (nq.size() != 0) & ordy;
    if (nq.size() != 0 && !ordy && n_cnt < 65535) n_cnt++;
    if (fl) nq.delete();
    else begin
      if (pp) void'(nq.pop_front());
      if (ps) nq.push_back('{c: c, d: d});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] held;

    // Power-on reset.
    #1 reset = 1'b0;
    #1;
    check_eq("rst_out_valid", DW'(m_out_valid), DW'(0));
    check_eq("rst_out_data", m_out_data, DW'(0));
    check_eq("rst_out_ctrl", DW'(m_out_ctrl), DW'(0));
    check_eq("rst_stall_cnt", DW'(m_stall), DW'(0));
    check_eq("rst_in_ready", DW'(m_in_ready), DW'(0));
    check_eq("rst_n_in_ready", DW'(n_in_ready), DW'(0));
    #10 reset = 1'b1;
    #1;
    check_eq("rel_in_ready_low", DW'(m_in_ready), DW'(0));
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    n_started = 1'b1;

    // Back-to-back pushes with downstream always ready.
    cyc_m(1'b1, DW'(32'h11), CW'(19'h1), 1'b1, 1'b0);
    cyc_m(1'b1, DW'(32'h22), CW'(19'h2), 1'b1, 1'b0);
    cyc_m(1'b0, '0, '0, 1'b1, 1'b0);
    cyc_m(1'b0, '0, '0, 1'b1, 1'b0);

    // Stall: A held, B into skid, C refused until space opens; then drain in order.
    cyc_m(1'b1, DW'(32'hA), CW'(19'h3), 1'b0, 1'b0);
    cyc_m(1'b1, DW'(32'hB), CW'(19'h4), 1'b0, 1'b0);
    cyc_m(1'b1, DW'(32'hC), CW'(19'h5), 1'b0, 1'b0);
    cyc_m(1'b1, DW'(32'hC), CW'(19'h5), 1'b0, 1'b0);
    cyc_m(1'b1, DW'(32'hC), CW'(19'h5), 1'b1, 1'b0);
    cyc_m(1'b1, DW'(32'hC), CW'(19'h5), 1'b1, 1'b0);
    cyc_m(1'b0, '0, '0, 1'b1, 1'b0);
    cyc_m(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush while FULL with a push offered.
    cyc_m(1'b1, DW'(32'h31), CW'(19'h6), 1'b0, 1'b0);
    cyc_m(1'b1, DW'(32'h32), CW'(19'h7), 1'b0, 1'b0);
    cyc_m(1'b1, DW'(32'h33), CW'(19'h8), 1'b0, 1'b1);
    cyc_m(1'b0, '0, '0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a stream with the stage FULL.
    cyc_m(1'b1, DW'(32'h41), CW'(19'h9), 1'b0, 1'b0);
    cyc_m(1'b1, DW'(32'h42), CW'(19'hA), 1'b0, 1'b0);
    m_in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("amid_out_valid", DW'(m_out_valid), DW'(0));
    check_eq("amid_out_ctrl", DW'(m_out_ctrl), DW'(0));
    check_eq("amid_stall_cnt", DW'(m_stall), DW'(0));
    check_eq("amid_in_ready", DW'(m_in_ready), DW'(0));
    mq.delete(); nq.delete();
    m_cnt = 0; n_cnt = 0;
    m_rdy = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    m_rdy = 1'b1;

    // Random traffic with occasional flush on the skid instance.
    for (int i = 0; i < 400; i++) begin
      cyc_m(($urandom % 4) != 0, rnd_data(), CW'($urandom), ($urandom % 3) != 0,
            ($urandom % 20) == 0);
    end
    cyc_m(1'b0, '0, '0, 1'b1, 1'b0);
    cyc_m(1'b0, '0, '0, 1'b1, 1'b0);

    // 4-bit stall counter saturates at 15 and holds with the payload stable.
    held = rnd_data();
    c_in_valid = 1'b1; c_in_data = held; c_in_ctrl = CW'(19'h55); c_out_ready = 1'b0;
    @(posedge clk);
    #1;
    c_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_eq("c_out_valid", DW'(c_out_valid), DW'(1));
      check_eq("c_out_data_held", c_out_data, held);
      check_eq("c_stall_cnt", DW'(c_stall), DW'((i < 15) ? i : 15));
      @(posedge clk);
      #1;
    end
    check_eq("c_stall_sat", DW'(c_stall), DW'(15));

    // Random traffic on the single-entry instance.
    for (int i = 0; i < 1000; i++) begin
      cyc_n(($urandom % 3) != 0, rnd_data(), CW'($urandom), ($urandom % 3) != 0,
            ($urandom % 25) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
